// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the floating-point multiplier controller.
// Holds the controller state encoding and the IEEE-754 single-precision constants.
package fp_mul_pkg;

  localparam int MANT_W = 24;
  localparam logic signed [9:0] FP_BIAS = 10'sd127;
  localparam logic signed [9:0] FP_EXP_MAX = 10'sd254;
  localparam logic [22:0] FP_NAN_MANT = 23'h1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    RESP
  } state_t;

  function automatic logic [31:0] fp_nan(input logic s);
    return {s, 8'hFF, FP_NAN_MANT};
  endfunction

  function automatic logic [31:0] fp_zero(input logic s);
    return {s, 31'b0};
  endfunction

endpackage

// File: rtl/fp_mul_ctrl_if.sv
// Request/response bundle between the two requesters, the consumer and fp_mul_ctrl.
// master = requester/consumer side, slave = the controller.
interface fp_mul_ctrl_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/mant_mul_seq.sv
// Shift-add unsigned MANT_W x MANT_W multiplier; bit 0 of b is folded into the load,
// the remaining bits take one cycle each, and done pulses as the final product settles.
module mant_mul_seq
  import fp_mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W-1:0]     b,
  output logic                  done,
  output logic [2*MANT_W-1:0]   p
);

  localparam int CNT_W = $clog2(MANT_W);

  logic [2*MANT_W-1:0] mcand;
  logic [MANT_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p       <= b[0] ? {{MANT_W{1'b0}}, a} : '0;
        mcand   <= {{(MANT_W-1){1'b0}}, a, 1'b0};
        mplier  <= b >> 1;
        cnt     <= CNT_W'(MANT_W - 1);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          p <= p + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_mul_ctrl.sv
// Arbitrates two requesters onto one iterative FP32 multiplier, normalises and packs the result.
// Define FP_MUL_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fp_mul_ctrl
  import fp_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fp_mul_ctrl_if.slave  bus,
  output logic          busy
);

  state_t state, state_nxt;

  logic                grant;
  logic                accept;
  logic [31:0]         sel_a;
  logic [31:0]         sel_b;
  logic                sign;
  logic                zero_op;
  logic                inf_op;
  logic                special;
  logic [31:0]         special_res;
  logic signed [9:0]   exp_sum;

  logic                id_q;
  logic                sign_q;
  logic signed [9:0]   exp_q;
  logic                special_q;
  logic [31:0]         result_q;

  logic                mul_start;
  logic                mul_done;
  logic [2*MANT_W-1:0] prod;

  logic signed [9:0]   exp_norm;
  logic [22:0]         mant_norm;
  logic [31:0]         norm_res;
  logic                unused_prod_lsbs;

`ifdef FP_MUL_CTRL_RR_EN
  logic last_grant;

  always_comb begin
    grant = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      grant = ~last_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`else
  always_comb begin
    grant = ~bus.req_valid[0];
  end
`endif

  // Ready is masked during reset so the bus shows its reset values while rst_n is low.
  always_comb begin
    sel_a       = grant ? bus.req_a[63:32] : bus.req_a[31:0];
    sel_b       = grant ? bus.req_b[63:32] : bus.req_b[31:0];
    accept      = (state == IDLE) && rst_n && bus.req_valid[grant];
    sign        = sel_a[31] ^ sel_b[31];
    zero_op     = (sel_a[30:23] == 8'h00) || (sel_b[30:23] == 8'h00);
    inf_op      = (sel_a[30:23] == 8'hFF) || (sel_b[30:23] == 8'hFF);
    special     = zero_op || inf_op;
    special_res = zero_op ? fp_zero(sign) : fp_nan(sign);
    exp_sum     = $signed({2'b00, sel_a[30:23]}) + $signed({2'b00, sel_b[30:23]}) - FP_BIAS;
    mul_start   = accept && !special;
  end

  mant_mul_seq u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     ({1'b1, sel_a[22:0]}),
    .b     ({1'b1, sel_b[22:0]}),
    .done  (mul_done),
    .p     (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Special operands still pass through NORM for one cycle so the bypass answers one edge
  // after acceptance; NORM leaves their precomputed result untouched.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready = grant ? 2'b10 : 2'b01;
          state_nxt     = special ? NORM : MUL;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_nxt = NORM;
        end
      end
      NORM: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    exp_norm  = exp_q;
    mant_norm = prod[45:23];
    if (prod[47]) begin
      exp_norm  = exp_q + 10'sd1;
      mant_norm = prod[46:24];
    end
    if (exp_norm > FP_EXP_MAX) begin
      norm_res = fp_nan(sign_q);
    end else if (exp_norm < 10'sd1) begin
      norm_res = fp_zero(sign_q);
    end else begin
      norm_res = {sign_q, exp_norm[7:0], mant_norm};
    end
    unused_prod_lsbs = ^prod[22:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        id_q      <= grant;
        sign_q    <= sign;
        exp_q     <= exp_sum;
        special_q <= special;
        if (special) begin
          result_q <= special_res;
        end
      end
      if (state == NORM && !special_q) begin
        result_q <= norm_res;
      end
    end
  end

  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;

endmodule

// File: tb/tb_fp_mul_ctrl.sv
// Self-checking bench for fp_mul_ctrl: directed vectors, random operands against an
// arithmetic reference model, backpressure, contention and mid-operation reset.
module tb_fp_mul_ctrl;
  import fp_mul_pkg::*;

  localparam int LAT_MUL  = MANT_W + 1;
  localparam int LAT_BYP  = 1;
  localparam int WAIT_MAX = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int compared   = 0;
  int mismatched = 0;

  fp_mul_ctrl_if bus ();

  fp_mul_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  // Reference: real product of the 24-bit significands, then the truncate/normalise rules.
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    int          ea;
    int          eb;
    int          e;
    longint      p;
    logic        s;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {s, 31'b0};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h1};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      m = 23'((p >> 24) & 64'h7FFFFF);
      e = e + 1;
    end else begin
      m = 23'((p >> 23) & 64'h7FFFFF);
    end
    if (e > 254) return {s, 8'hFF, 23'h1};
    if (e < 1) return {s, 31'b0};
    return {s, 8'(e), m};
  endfunction

  function automatic bit isSpecial(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (b[30:23] == 8'h00) ||
           (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] randOperand();
    logic [7:0] e;
    int         r;
    r = $urandom_range(0, 9);
    case (r)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1);
    bus.req_valid = valid;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
  endtask

  // One complete transaction from a single requester with the consumer always ready.
  task automatic doOp(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expRes, input int expLat, input string name);
    int waits;
    int lat;
    bus.rsp_ready = 1'b1;
    if (id) applyStimulus(2'b10, 32'h0, 32'h0, a, b);
    else    applyStimulus(2'b01, a, b, 32'h0, 32'h0);
    #1;
    waits = 0;
    while (!bus.req_ready[id] && waits < WAIT_MAX) begin
      tick();
      #1;
      waits++;
    end
    checkOutput({name, "_ready"}, 32'(bus.req_ready), id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    lat = 0;
    while (!bus.rsp_valid && lat < WAIT_MAX) begin
      tick();
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_result"}, bus.rsp_result, expRes);
    checkOutput({name, "_id"}, 32'(bus.rsp_id), 32'(id));
    tick();
    checkOutput({name, "_rsp_clear"}, 32'({bus.rsp_valid, busy}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rid;
    logic        exp_id;
    int          waits;
    int          lat;

    vecs[0] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, LAT_MUL, "two_x_three"};
    vecs[1] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, LAT_MUL, "norm_shift"};
    vecs[2] = '{1'b0, 32'h80000000, 32'h40400000, 32'h80000000, LAT_BYP, "neg_zero"};
    vecs[3] = '{1'b1, 32'h00400000, 32'h3F800000, 32'h00000000, LAT_BYP, "denorm_flush"};
    vecs[4] = '{1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800001, LAT_MUL, "overflow"};
    vecs[5] = '{1'b1, 32'h00800000, 32'h00800000, 32'h00000000, LAT_MUL, "underflow"};
    vecs[6] = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800001, LAT_BYP, "inf_nan"};
    vecs[7] = '{1'b1, 32'hC0000000, 32'h40400000, 32'hC0C00000, LAT_MUL, "neg_product"};

    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.rsp_ready = 1'b1;
    #3;
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("rst_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    applyStimulus(2'b11, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      doOp(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);
    end

    $display("[TB] random operands against reference model");
    for (int i = 0; i < 24; i++) begin
      rid = 1'($urandom);
      ra  = randOperand();
      rb  = randOperand();
      doOp(rid, ra, rb, refMul(ra, rb), isSpecial(ra, rb) ? LAT_BYP : LAT_MUL, "rand");
    end

    $display("[TB] response backpressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(2'b10, 32'h0, 32'h0, 32'h3FC00000, 32'h3FC00000);
    #1;
    waits = 0;
    while (!bus.req_ready[1] && waits < WAIT_MAX) begin
      tick();
      #1;
      waits++;
    end
    checkOutput("bp_ready", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 32'h80000000, 32'h40400000, 32'h0, 32'h0);
    lat = 0;
    while (!bus.rsp_valid && lat < WAIT_MAX) begin
      tick();
      lat++;
    end
    checkOutput("bp_latency", 32'(lat), 32'(LAT_MUL));
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_hold_result", bus.rsp_result, 32'h40100000);
      checkOutput("bp_hold_id", 32'(bus.rsp_id), 32'd1);
      checkOutput("bp_hold_no_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("bp_release", 32'(bus.rsp_valid), 32'd0);
    doOp(1'b0, 32'h80000000, 32'h40400000, 32'h80000000, LAT_BYP, "bp_next");

    $display("[TB] reset during multiply");
    applyStimulus(2'b10, 32'h0, 32'h0, 32'h3FC00000, 32'h3FC00000);
    #1;
    waits = 0;
    while (!bus.req_ready[1] && waits < WAIT_MAX) begin
      tick();
      #1;
      waits++;
    end
    checkOutput("mid_ready", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 32'h40000000, 32'h40400000, 32'h0, 32'h0);
    repeat (5) tick();
    checkOutput("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("mid_rst_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      checkOutput("post_rst_no_rsp", 32'({bus.rsp_valid, busy}), 32'd0);
    end

    $display("[TB] contention, both requesters valid");
    applyStimulus(2'b11, 32'h40000000, 32'h40400000, 32'hC0000000, 32'h3FC00000);
    #1;
    for (int g = 0; g < 4; g++) begin
`ifdef FP_MUL_CTRL_RR_EN
      exp_id = (g % 2) == 1;
`else
      exp_id = 1'b0;
`endif
      waits = 0;
      while (bus.req_ready == 2'b00 && waits < WAIT_MAX) begin
        tick();
        #1;
        waits++;
      end
      checkOutput("arb_grant", 32'(bus.req_ready), exp_id ? 32'd2 : 32'd1);
      checkOutput("arb_ready_wait", 32'(waits), 32'd0);
      @(posedge clk);
      #1;
      lat = 0;
      while (!bus.rsp_valid && lat < WAIT_MAX) begin
        tick();
        lat++;
      end
      checkOutput("arb_latency", 32'(lat), 32'(LAT_MUL));
      checkOutput("arb_id", 32'(bus.rsp_id), 32'(exp_id));
      checkOutput("arb_result", bus.rsp_result,
                  exp_id ? refMul(32'hC0000000, 32'h3FC00000) : refMul(32'h40000000, 32'h40400000));
      tick();
      #1;
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
